// File: rtl/reset_pkg.sv
// Shared types and constants for the reset sequencer and its domain handshakes.
package reset_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FULL_HOLD = 3'd1,
        S_DATA_REQ  = 3'd2,
        S_IO_REQ    = 3'd3,
        S_INST_REQ  = 3'd4,
        S_RESPOND   = 3'd5
    } reset_seq_state_t;

    localparam int unsigned RST_FULL = 3;
    localparam int unsigned RST_INST = 2;
    localparam int unsigned RST_IO   = 1;
    localparam int unsigned RST_DATA = 0;

    // First selected domain in data -> IO -> inst order; RESPOND when none remain.
    function automatic reset_seq_state_t first_domain(input logic [2:0] sel);
        if (sel[RST_DATA]) return S_DATA_REQ;
        if (sel[RST_IO])   return S_IO_REQ;
        if (sel[RST_INST]) return S_INST_REQ;
        return S_RESPOND;
    endfunction

endpackage

// File: rtl/reset_domain_handshake.sv
// One reset domain: holds its request until ack or timeout and keeps a sticky timeout flag.
module reset_domain_handshake (
    input  logic clk,
    input  logic async_rst,
    input  logic clk_en,
    input  logic i_start,
    input  logic i_ack,
    input  logic i_timeout_hit,
    input  logic i_clear_flag,
    output logic o_req,
    output logic o_done_c,
    output logic o_timed_out
);

    logic r_req;
    logic r_flag;

    // Ack takes priority over a coincident timeout.
    assign o_done_c    = r_req & (i_ack | i_timeout_hit);
    assign o_req       = r_req;
    assign o_timed_out = r_flag;

    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            r_req  <= 1'b0;
            r_flag <= 1'b0;
        end else if (clk_en) begin
            if (i_start) begin
                r_req <= 1'b1;
            end else if (o_done_c) begin
                r_req <= 1'b0;
            end
            if (i_clear_flag) begin
                r_flag <= 1'b0;
            end else if (r_req && !i_ack && i_timeout_hit) begin
                r_flag <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// Sequences per-domain reset requests or a timed full-system reset from a software reset pulse.
module reset_sequencer
    import reset_pkg::*;
#(
    parameter int unsigned FULL_RESET_CYCLES = 16,
    parameter int unsigned TIMEOUT_CYCLES    = 255
) (
    input  logic       clk,
    input  logic       async_rst,
    input  logic       clk_en,
    input  logic       SoftwareResetIn,
    input  logic [3:0] ResetVectorIn,
    output logic       DataResetReq,
    input  logic       DataResetAck,
    output logic       IOResetReq,
    input  logic       IOResetAck,
    output logic       InstResetReq,
    input  logic       InstResetAck,
    output logic       FullResetOut,
    output logic       ResetResponseOut,
    output logic       Busy,
    output logic [2:0] TimeoutFlags
);

    localparam int unsigned CNT_MAX = (FULL_RESET_CYCLES > TIMEOUT_CYCLES) ?
                                      FULL_RESET_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    reset_seq_state_t r_state;
    reset_seq_state_t w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_sel;
    logic             r_full;
    logic             r_resp;
    logic             r_busy;
    logic             w_sel_load;
    logic             w_sel_clear;
    logic             w_flag_clr;
    logic             w_to_hit;
    logic             w_full_done;
    logic [2:0]       w_start;
    logic [2:0]       w_ack;
    logic [2:0]       w_done;
    logic [2:0]       w_req;
    logic [2:0]       w_flag;

    assign w_ack       = {InstResetAck, IOResetAck, DataResetAck};
    assign w_to_hit    = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign w_full_done = (r_cnt == CNT_W'(FULL_RESET_CYCLES - 1));

    // Next-state decode and domain start strobes.
    always_comb begin
        w_state_next = r_state;
        w_sel_load   = 1'b0;
        w_sel_clear  = 1'b0;
        w_flag_clr   = 1'b0;
        w_start      = 3'b000;
        case (r_state)
            S_IDLE: begin
                if (SoftwareResetIn) begin
                    w_sel_load = 1'b1;
                    if (ResetVectorIn[RST_FULL]) begin
                        w_state_next = S_FULL_HOLD;
                    end else if (ResetVectorIn[2:0] != 3'b000) begin
                        w_state_next = first_domain(ResetVectorIn[2:0]);
                    end
                end
            end
            S_FULL_HOLD: begin
                if (w_full_done) begin
                    w_state_next = S_IDLE;
                    w_sel_clear  = 1'b1;
                    w_flag_clr   = 1'b1;
                end
            end
            S_DATA_REQ: begin
                if (w_done[RST_DATA]) begin
                    w_state_next = first_domain({r_sel[RST_INST], r_sel[RST_IO], 1'b0});
                end
            end
            S_IO_REQ: begin
                if (w_done[RST_IO]) begin
                    w_state_next = first_domain({r_sel[RST_INST], 2'b00});
                end
            end
            S_INST_REQ: begin
                if (w_done[RST_INST]) begin
                    w_state_next = S_RESPOND;
                end
            end
            S_RESPOND: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
        w_start[RST_DATA] = (w_state_next == S_DATA_REQ) && (r_state != S_DATA_REQ);
        w_start[RST_IO]   = (w_state_next == S_IO_REQ)   && (r_state != S_IO_REQ);
        w_start[RST_INST] = (w_state_next == S_INST_REQ) && (r_state != S_INST_REQ);
    end

    // State, shared counter, latched selection and registered status outputs.
    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_sel   <= 3'b000;
            r_full  <= 1'b0;
            r_resp  <= 1'b0;
            r_busy  <= 1'b0;
        end else if (clk_en) begin
            r_state <= w_state_next;
            if (w_state_next != r_state) begin
                r_cnt <= '0;
            end else if (r_state != S_IDLE && r_state != S_RESPOND) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_sel_load) begin
                r_sel <= ResetVectorIn[2:0];
            end else if (w_sel_clear) begin
                r_sel <= 3'b000;
            end
            r_full <= (w_state_next == S_FULL_HOLD);
            r_resp <= (w_state_next == S_RESPOND);
            r_busy <= (w_state_next != S_IDLE);
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_dom
        reset_domain_handshake u_hs (
            .clk          (clk),
            .async_rst    (async_rst),
            .clk_en       (clk_en),
            .i_start      (w_start[g]),
            .i_ack        (w_ack[g]),
            .i_timeout_hit(w_to_hit),
            .i_clear_flag (w_flag_clr),
            .o_req        (w_req[g]),
            .o_done_c     (w_done[g]),
            .o_timed_out  (w_flag[g])
        );
    end

    assign DataResetReq     = w_req[RST_DATA];
    assign IOResetReq       = w_req[RST_IO];
    assign InstResetReq     = w_req[RST_INST];
    assign TimeoutFlags     = w_flag;
    assign FullResetOut     = r_full;
    assign ResetResponseOut = r_resp;
    assign Busy             = r_busy;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: per-cycle expected outputs queued ahead and compared at negedge.
module tb_reset_sequencer;

    localparam int unsigned FULL_N = 16;
    localparam int unsigned TO_N   = 8;

    logic       clk = 1'b0;
    logic       async_rst;
    logic       clk_en;
    logic       SoftwareResetIn;
    logic [3:0] ResetVectorIn;
    logic       DataResetReq, DataResetAck;
    logic       IOResetReq, IOResetAck;
    logic       InstResetReq, InstResetAck;
    logic       FullResetOut, ResetResponseOut, Busy;
    logic [2:0] TimeoutFlags;

    int n_total = 0;
    int n_pass  = 0;
    logic [8:0] exp_q[$];

    always #5 clk = ~clk;

    reset_sequencer #(
        .FULL_RESET_CYCLES(FULL_N),
        .TIMEOUT_CYCLES   (TO_N)
    ) dut (
        .clk             (clk),
        .async_rst       (async_rst),
        .clk_en          (clk_en),
        .SoftwareResetIn (SoftwareResetIn),
        .ResetVectorIn   (ResetVectorIn),
        .DataResetReq    (DataResetReq),
        .DataResetAck    (DataResetAck),
        .IOResetReq      (IOResetReq),
        .IOResetAck      (IOResetAck),
        .InstResetReq    (InstResetReq),
        .InstResetAck    (InstResetAck),
        .FullResetOut    (FullResetOut),
        .ResetResponseOut(ResetResponseOut),
        .Busy            (Busy),
        .TimeoutFlags    (TimeoutFlags)
    );

    // Output snapshot layout: {data, io, inst, full, resp, busy, flags[2:0]}.
    function automatic logic [8:0] pat(input logic d, input logic io, input logic in,
                                       input logic f, input logic r, input logic b,
                                       input logic [2:0] fl);
        return {d, io, in, f, r, b, fl};
    endfunction

    task automatic push(input int n, input logic [8:0] p);
        repeat (n) exp_q.push_back(p);
    endtask

    task automatic compare_now(input string tag, input int idx);
        logic [8:0] obs;
        logic [8:0] exp_v;
        obs = {DataResetReq, IOResetReq, InstResetReq, FullResetOut,
               ResetResponseOut, Busy, TimeoutFlags};
        n_total++;
        if (exp_q.size() == 0) begin
            $error("FAIL %s[%0d]: observed=%b but no expected entry queued", tag, idx, obs);
        end else begin
            exp_v = exp_q.pop_front();
            assert (obs === exp_v) n_pass++;
            else $error("FAIL %s[%0d]: observed=%b expected=%b", tag, idx, obs, exp_v);
        end
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            compare_now(tag, i);
        end
    endtask

    initial begin
        async_rst       = 1'b1;
        clk_en          = 1'b1;
        SoftwareResetIn = 1'b0;
        ResetVectorIn   = 4'b0000;
        DataResetAck    = 1'b0;
        IOResetAck      = 1'b0;
        InstResetAck    = 1'b0;

        push(1, pat(0,0,0,0,0,0,3'b000));
        run(1, "reset");
        async_rst = 1'b0;

        // Empty vector: no-op
        push(2, pat(0,0,0,0,0,0,3'b000));
        SoftwareResetIn = 1'b1; ResetVectorIn = 4'b0000;
        run(1, "noop");
        SoftwareResetIn = 1'b0;
        run(1, "noop");

        // Data only, ack two cycles after request rises
        push(3, pat(1,0,0,0,0,1,3'b000));
        push(1, pat(0,0,0,0,1,1,3'b000));
        push(1, pat(0,0,0,0,0,0,3'b000));
        SoftwareResetIn = 1'b1; ResetVectorIn = 4'b0001;
        run(1, "data_ack");
        SoftwareResetIn = 1'b0;
        run(2, "data_ack");
        DataResetAck = 1'b1;
        run(1, "data_ack");
        DataResetAck = 1'b0;
        run(1, "data_ack");

        // All three domains, acks tied high
        DataResetAck = 1'b1; IOResetAck = 1'b1; InstResetAck = 1'b1;
        push(1, pat(1,0,0,0,0,1,3'b000));
        push(1, pat(0,1,0,0,0,1,3'b000));
        push(1, pat(0,0,1,0,0,1,3'b000));
        push(1, pat(0,0,0,0,1,1,3'b000));
        push(1, pat(0,0,0,0,0,0,3'b000));
        SoftwareResetIn = 1'b1; ResetVectorIn = 4'b0111;
        run(1, "all_dom");
        SoftwareResetIn = 1'b0;
        run(4, "all_dom");
        DataResetAck = 1'b0; IOResetAck = 1'b0; InstResetAck = 1'b0;

        // IO timeout
        push(TO_N, pat(0,1,0,0,0,1,3'b000));
        push(1, pat(0,0,0,0,1,1,3'b010));
        push(1, pat(0,0,0,0,0,0,3'b010));
        SoftwareResetIn = 1'b1; ResetVectorIn = 4'b0010;
        run(1, "io_tmo");
        SoftwareResetIn = 1'b0;
        run(TO_N + 1, "io_tmo");

        // Full-reset pulse during IO_REQ is ignored
        push(4, pat(0,1,0,0,0,1,3'b010));
        push(1, pat(0,0,0,0,1,1,3'b010));
        push(1, pat(0,0,0,0,0,0,3'b010));
        SoftwareResetIn = 1'b1; ResetVectorIn = 4'b0010;
        run(1, "ignore");
        SoftwareResetIn = 1'b0;
        run(1, "ignore");
        SoftwareResetIn = 1'b1; ResetVectorIn = 4'b1000;
        run(1, "ignore");
        SoftwareResetIn = 1'b0;
        run(1, "ignore");
        IOResetAck = 1'b1;
        run(1, "ignore");
        IOResetAck = 1'b0;
        run(1, "ignore");

        // clk_en low 5 cycles mid-request stretches the timeout by 5
        push(TO_N + 5, pat(0,1,0,0,0,1,3'b010));
        push(1, pat(0,0,0,0,1,1,3'b010));
        push(1, pat(0,0,0,0,0,0,3'b010));
        SoftwareResetIn = 1'b1; ResetVectorIn = 4'b0010;
        run(1, "stall");
        SoftwareResetIn = 1'b0;
        run(2, "stall");
        clk_en = 1'b0;
        run(5, "stall");
        clk_en = 1'b1;
        run(7, "stall");

        // Full reset overrides domain bits and clears flags at completion
        push(FULL_N, pat(0,0,0,1,0,1,3'b010));
        push(1, pat(0,0,0,0,0,0,3'b000));
        SoftwareResetIn = 1'b1; ResetVectorIn = 4'b1110;
        run(1, "full");
        SoftwareResetIn = 1'b0;
        run(FULL_N, "full");

        // Data timeout then INST_REQ, async reset mid-request
        push(TO_N, pat(1,0,0,0,0,1,3'b000));
        push(2, pat(0,0,1,0,0,1,3'b001));
        SoftwareResetIn = 1'b1; ResetVectorIn = 4'b0101;
        run(1, "d_then_i");
        SoftwareResetIn = 1'b0;
        run(TO_N + 1, "d_then_i");
        #2 async_rst = 1'b1;
        push(1, pat(0,0,0,0,0,0,3'b000));
        #1 compare_now("async", 0);
        push(1, pat(0,0,0,0,0,0,3'b000));
        run(1, "in_rst");
        async_rst = 1'b0;

        // Normal sequence after async reset, immediate ack
        DataResetAck = 1'b1;
        push(1, pat(1,0,0,0,0,1,3'b000));
        push(1, pat(0,0,0,0,1,1,3'b000));
        push(1, pat(0,0,0,0,0,0,3'b000));
        SoftwareResetIn = 1'b1; ResetVectorIn = 4'b0001;
        run(1, "post_rst");
        SoftwareResetIn = 1'b0;
        run(2, "post_rst");
        DataResetAck = 1'b0;

        // Ack on the timeout edge wins: no flag
        push(TO_N, pat(1,0,0,0,0,1,3'b000));
        push(1, pat(0,0,0,0,1,1,3'b000));
        push(1, pat(0,0,0,0,0,0,3'b000));
        SoftwareResetIn = 1'b1; ResetVectorIn = 4'b0001;
        run(1, "ack_tmo");
        SoftwareResetIn = 1'b0;
        run(TO_N - 1, "ack_tmo");
        DataResetAck = 1'b1;
        run(1, "ack_tmo");
        DataResetAck = 1'b0;
        run(1, "ack_tmo");

        n_total++;
        assert (exp_q.size() == 0) n_pass++;
        else $error("FAIL sb_drain: observed=%0d leftover entries expected=0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
